// File: rtl/mux4_pkg.sv
// Shared definitions for the four-way round-robin mux scheduler.
// Holds the requester count, the select width, the FSM state encoding
// and the helper that turns an owner index into a one-hot grant.
package mux4_pkg;

   localparam int N_REQ = 4;
   localparam int SEL_W = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // Owner index -> one-hot grant vector (index 0 -> bit 0 -> mux input i1).
   function automatic logic [N_REQ-1:0] idx2onehot(input logic [SEL_W-1:0] idx);
      logic [N_REQ-1:0] oh;
      oh      = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of mask, starting the
// search just after 'last' and wrapping mod 4.
// Ports: mask (candidates), last (previous winner) -> winner index, found flag.
module rr_pick
   import mux4_pkg::*;
(
   input  logic [N_REQ-1:0] mask,
   input  logic [SEL_W-1:0] last,
   output logic [SEL_W-1:0] winner,
   output logic             found
);

   always_comb begin
      winner = last;
      found  = 1'b0;
      // Offsets 1..4 from 'last'; offset 4 wraps back onto 'last' itself,
      // so the previous winner has the lowest priority.
      for (int k = 1; k <= N_REQ; k++) begin
         if (!found && mask[SEL_W'(last + SEL_W'(k))]) begin
            winner = SEL_W'(last + SEL_W'(k));
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux4_rr_sched.sv
// Round-robin scheduler sharing one mux4_1 among four requesters, with a
// bounded slot per owner. Drives registered one-hot gnt plus mux selects
// s1 (MSB) / s2 (LSB); busy = |gnt.
// Ports: clk, rst (async, active-high), req[3:0] in; gnt[3:0], s1, s2, busy out.
module mux4_rr_sched
   import mux4_pkg::*;
#(
   parameter int SLOT_CYCLES = 4,
   parameter int CNT_W       = 3
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic             s1,
   output logic             s2,
   output logic             busy
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SLOT_CYCLES - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [SEL_W-1:0] last, last_nxt;
   logic [SEL_W-1:0] sel, sel_nxt;
   logic [N_REQ-1:0] gnt_nxt;

   logic [N_REQ-1:0] cand;
   logic [SEL_W-1:0] win;
   logic             win_found;
   logic             own_req;

   // While idle every request competes; while granted only the others do,
   // so a rotation never hands the mux straight back to the current owner.
   assign cand    = (state == IDLE) ? req : (req & ~gnt);
   assign own_req = |(req & gnt);

   rr_pick u_pick (
      .mask   (cand),
      .last   (last),
      .winner (win),
      .found  (win_found)
   );

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      last_nxt  = last;
      sel_nxt   = sel;
      gnt_nxt   = gnt;

      case (state)
         IDLE: begin
            if (win_found) begin
               state_nxt = GRANT;
               cnt_nxt   = '0;
               last_nxt  = win;
               sel_nxt   = win;
               gnt_nxt   = idx2onehot(win);
            end
         end

         GRANT: begin
            if (!own_req) begin
               // Owner dropped; this also covers a drop that coincides with
               // slot expiry. Hand over without a bubble if anyone waits.
               cnt_nxt = '0;
               if (win_found) begin
                  last_nxt = win;
                  sel_nxt  = win;
                  gnt_nxt  = idx2onehot(win);
               end else begin
                  state_nxt = IDLE;
                  gnt_nxt   = '0;
               end
            end else if (cnt == CNT_MAX) begin
               // Slot used up: rotate if contended, otherwise the owner keeps
               // the mux and starts a fresh slot.
               cnt_nxt = '0;
               if (win_found) begin
                  last_nxt = win;
                  sel_nxt  = win;
                  gnt_nxt  = idx2onehot(win);
               end
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end

         default: begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
            cnt_nxt   = '0;
         end
      endcase
   end

   // last resets to 3 so requester 0 is searched first after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         last  <= SEL_W'(N_REQ - 1);
         sel   <= '0;
         gnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         last  <= last_nxt;
         sel   <= sel_nxt;
         gnt   <= gnt_nxt;
      end
   end

   // gnt and sel share one register update, so they always move together.
   assign s1   = sel[1];
   assign s2   = sel[0];
   assign busy = |gnt;

endmodule

// File: tb/tb_mux4_rr_sched.sv
module tb_mux4_rr_sched;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic [3:0] req1;
   logic [3:0] gnt, gnt1;
   logic       s1, s2, busy;
   logic       s1_1, s2_1, busy1;

   int checks = 0;
   int errors = 0;

   // Data on mux inputs i1..i4 and the mux4_1 output selected by {s1,s2}.
   logic [7:0] i_val [4];
   logic [7:0] y;

   always #5 clk = ~clk;

   mux4_rr_sched #(.SLOT_CYCLES(4), .CNT_W(3)) dut (
      .clk  (clk),
      .rst  (rst),
      .req  (req),
      .gnt  (gnt),
      .s1   (s1),
      .s2   (s2),
      .busy (busy)
   );

   mux4_rr_sched #(.SLOT_CYCLES(1), .CNT_W(1)) dut1 (
      .clk  (clk),
      .rst  (rst),
      .req  (req1),
      .gnt  (gnt1),
      .s1   (s1_1),
      .s2   (s2_1),
      .busy (busy1)
   );

   assign y = i_val[{s1, s2}];

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset;
      rst  = 1'b1;
      req  = 4'b1111;
      req1 = 4'b0000;
      #3;
      checks++;
      if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
      checks++;
      if ({s1, s2} !== 2'b00) begin errors++; $display("FAIL reset_sel got=%b exp=00", {s1, s2}); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      rst = 1'b0;
      step();
      checks++;
      if (gnt !== 4'b0001) begin errors++; $display("FAIL first_grant got=%b exp=0001", gnt); end
      // Asynchronous clear between clock edges.
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (gnt !== 4'b0000) begin errors++; $display("FAIL async_rst_gnt got=%b exp=0000", gnt); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL async_rst_busy got=%b exp=0", busy); end
      req = 4'b0000;
      rst = 1'b0;
   endtask

   task automatic test_single;
      step();
      req = 4'b0100;
      step();
      checks++;
      if (gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt got=%b exp=0100", gnt); end
      checks++;
      if ({s1, s2} !== 2'b10) begin errors++; $display("FAIL single_sel got=%b exp=10", {s1, s2}); end
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", busy); end
      for (int k = 0; k < 20; k++) begin
         step();
         checks++;
         if (gnt !== 4'b0100) begin errors++; $display("FAIL single_hold cyc=%0d got=%b exp=0100", k, gnt); end
      end
      req = 4'b0000;
      step();
      checks++;
      if (gnt !== 4'b0000) begin errors++; $display("FAIL single_release_gnt got=%b exp=0000", gnt); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL single_release_busy got=%b exp=0", busy); end
      checks++;
      if ({s1, s2} !== 2'b10) begin errors++; $display("FAIL single_release_sel got=%b exp=10", {s1, s2}); end
   endtask

   task automatic test_rotation;
      logic [1:0] o;
      logic [3:0] exp_g;
      do_reset();
      req = 4'b1111;
      for (int k = 0; k < 20; k++) begin
         step();
         o     = 2'((k / 4) % 4);
         exp_g = 4'b0001 << o;
         checks++;
         if (gnt !== exp_g) begin errors++; $display("FAIL rotate_gnt cyc=%0d got=%b exp=%b", k, gnt, exp_g); end
         checks++;
         if ({s1, s2} !== o) begin errors++; $display("FAIL rotate_sel cyc=%0d got=%b exp=%b", k, {s1, s2}, o); end
      end
      req = 4'b0000;
      step();
   endtask

   task automatic test_early_release;
      do_reset();
      req = 4'b0011;
      step();
      checks++;
      if (gnt !== 4'b0001) begin errors++; $display("FAIL early_first got=%b exp=0001", gnt); end
      step();
      req = 4'b0010;
      step();
      checks++;
      if (gnt !== 4'b0010) begin errors++; $display("FAIL early_gnt got=%b exp=0010", gnt); end
      checks++;
      if ({s1, s2} !== 2'b01) begin errors++; $display("FAIL early_sel got=%b exp=01", {s1, s2}); end
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL early_busy got=%b exp=1", busy); end
      req = 4'b0000;
      step();
   endtask

   task automatic test_drop_expiry;
      do_reset();
      req = 4'b1001;
      for (int k = 0; k < 4; k++) step();
      checks++;
      if (gnt !== 4'b0001) begin errors++; $display("FAIL dropexp_owner got=%b exp=0001", gnt); end
      req = 4'b1000;
      step();
      checks++;
      if (gnt !== 4'b1000) begin errors++; $display("FAIL dropexp_gnt got=%b exp=1000", gnt); end
      checks++;
      if ({s1, s2} !== 2'b11) begin errors++; $display("FAIL dropexp_sel got=%b exp=11", {s1, s2}); end
      req = 4'b0000;
      step();
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL dropexp_idle got=%b exp=0", busy); end
      req = 4'b0001;
      step();
      checks++;
      if (gnt !== 4'b0001) begin errors++; $display("FAIL dropexp_regrant got=%b exp=0001", gnt); end
      checks++;
      if ({s1, s2} !== 2'b00) begin errors++; $display("FAIL dropexp_regrant_sel got=%b exp=00", {s1, s2}); end
      req = 4'b0000;
      step();
   endtask

   task automatic test_slot1;
      logic [3:0] exp_g;
      do_reset();
      req1 = 4'b0110;
      for (int k = 0; k < 8; k++) begin
         step();
         exp_g = (k % 2 == 0) ? 4'b0010 : 4'b0100;
         checks++;
         if (gnt1 !== exp_g) begin errors++; $display("FAIL slot1_gnt cyc=%0d got=%b exp=%b", k, gnt1, exp_g); end
         checks++;
         if (busy1 !== 1'b1) begin errors++; $display("FAIL slot1_busy cyc=%0d got=%b exp=1", k, busy1); end
      end
      req1 = 4'b0000;
      step();
   endtask

   task automatic test_mux;
      logic [1:0] o;
      i_val[0] = 8'hA1;
      i_val[1] = 8'hB2;
      i_val[2] = 8'hC3;
      i_val[3] = 8'hD4;
      do_reset();
      req = 4'b1111;
      for (int k = 0; k < 16; k++) begin
         step();
         o = 2'((k / 4) % 4);
         checks++;
         if (y !== i_val[o]) begin errors++; $display("FAIL mux_y cyc=%0d got=%h exp=%h", k, y, i_val[o]); end
      end
      req = 4'b0000;
      step();
   endtask

   initial begin
      i_val[0] = 8'h00;
      i_val[1] = 8'h00;
      i_val[2] = 8'h00;
      i_val[3] = 8'h00;
      test_reset();
      test_single();
      test_rotation();
      test_early_release();
      test_drop_expiry();
      test_slot1();
      test_mux();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
